pc_stack: RTL
=============

# pc_stack

Parametrised program-counter unit for the CPU core, the next generation of the single-register PC. It adds a configurable address width, an internal return-address stack (RAS) for call/return, PC-relative jumps, a stall input, and sticky stack error flags. It sits between the decoder/control unit and instruction memory and drives the fetch address directly. Return addresses no longer travel through the data stack.

## Interface
Parameters:
- AW, 16, address width in bits; minimum 4.
- DEPTH, 8, number of RAS entries; minimum 2.
- RESET_VEC, 0, PC value loaded on reset, AW bits.

Ports:
- CLK  in  1  core clock; all state updates on the falling edge.
- RST_N  in  1  asynchronous active-low reset.
- stall  in  1  freezes PC, RAS and flags for this edge.
- pc_inc  in  1  advance PC by 1.
- jmp  in  1  absolute jump to target.
- jmp_rel  in  1  relative jump; target is a signed offset.
- call  in  1  push return address, then jump to target (absolute).
- ret  in  1  pop RAS into PC.
- target  in  AW  jump address or signed offset.
- clr_err  in  1  clears ras_ovf and ras_unf.
- pc  out  AW  current fetch address, registered.
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds DEPTH entries.
- ras_ovf  out  1  sticky; set when a call hits a full RAS.
- ras_unf  out  1  sticky; set when a ret hits an empty RAS.

## Operation
- Exactly one action per edge, chosen by fixed priority: stall > ret > call > jmp > jmp_rel > pc_inc. If none is asserted, the PC holds.
- pc_inc: pc <= pc + 1, modulo 2^AW. All-ones wraps to 0.
- jmp: pc <= target.
- jmp_rel: pc <= pc + sign-extended target, modulo 2^AW. The offset is relative to the current pc, not pc+1.
- call when not full: push pc+1 (wrapped), sp <= sp+1, pc <= target.
- call when full: jump still taken, push discarded, sp unchanged, ras_ovf <= 1.
- ret when not empty: pc <= top entry, sp <= sp-1.
- ret when empty: pc unchanged, sp unchanged, ras_unf <= 1.
- sp ranges 0..DEPTH and has width $clog2(DEPTH+1).
- ras_empty = (sp == 0) and ras_full = (sp == DEPTH). Both are decoded from the registered sp.
- clr_err clears both sticky flags on the edge. If clr_err coincides with a new error event, the error wins and the flag is set.
- stall also blocks clr_err.
- The FSM is implicit: the RAS occupancy counter is the only mode state.

## Timing
- Inputs are sampled at the falling edge of CLK. The new pc is visible immediately after that edge, giving one edge of latency per command.
- call followed by ret on the next edge returns the pc to the call address + 1, two edges after the call.
- No handshake: commands are single-edge strobes, and holding a strobe repeats the action each edge.
- RST_N low, asynchronously:
  - pc = RESET_VEC, sp = 0.
  - ras_empty = 1, ras_full = 0, ras_ovf = 0, ras_unf = 0.
  - RAS contents are not cleared and are don't-care.
- Reset mid-call or mid-return discards the in-flight push or pop.

## Structure
- pc_pkg:
  - Operation-select enum: NONE, INC, JMP, JREL, CALL, RET.
  - Priority encoder function from the strobe inputs to that enum.
  - Default AW, DEPTH and RESET_VEC constants.
- Sub-module ret_stack: DEPTH×AW LIFO with push, pop, top, sp, full and empty. It keeps its own RST_N-cleared pointer, and its storage is registers without reset.
- pc_stack holds the PC register, the adder/mux path and the sticky flags.

## Test plan
- Reset, then 3 pc_inc strobes -> pc 0x0000, 0x0001, 0x0002, 0x0003; ras_empty = 1.
- pc = 0x0010, call target 0x0200 -> pc = 0x0200, sp = 1. Then ret -> pc = 0x0011, ras_empty = 1.
- pc = 0x0100, jmp_rel target 0xFFF0 -> pc = 0x00F0. pc = 0xFFFF, pc_inc -> pc = 0x0000.
- Fill the RAS with 8 calls, then a 9th call to 0x0ABC -> pc = 0x0ABC, ras_full = 1, ras_ovf = 1. Then 8 rets -> the 8 pushed addresses in LIFO order.
- Empty RAS, ret -> pc unchanged, ras_unf = 1. Then clr_err together with stall -> flag stays 1. clr_err alone -> flag = 0.
- Simultaneous call and ret with sp = 1 -> ret taken, sp = 0. Then RST_N low mid-stream -> pc = RESET_VEC without waiting for a clock edge.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared types, defaults and the command priority encoder for pc_stack.
package pc_pkg;
  localparam int DEF_AW = 16;
  localparam int DEF_DEPTH = 8;
  localparam logic [63:0] DEF_RESET_VEC = '0;
  typedef enum logic [2:0] {
    NONE,
    INC,
    JMP,
    JREL,
    CALL,
    RET
  } op_e;
  // stall suppresses every command, so it maps to NONE
  function automatic op_e sel_op(input logic stall, input logic ret, input logic call,
                                 input logic jmp, input logic jmp_rel, input logic pc_inc);
    return stall ? NONE : ret ? RET : call ? CALL : jmp ? JMP : jmp_rel ? JREL :
           pc_inc ? INC : NONE;
  endfunction
endpackage

// File: rtl/pc_stack_ret_stack.sv
// ret_stack: DEPTH x AW return-address LIFO with reset pointer and unreset storage.
module ret_stack #(
  parameter int AW = 16,
  parameter int DEPTH = 8,
  localparam int SW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic [SW-1:0] sp,
  output logic          full,
  output logic          empty
);
  logic [AW-1:0] mem_q [DEPTH];
  logic [SW-1:0] sp_q, sp_d, sp_m1;
  logic do_push, do_pop;
  assign full = sp_q == SW'(DEPTH);
  assign empty = sp_q == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign sp_m1 = sp_q - 1'b1;
  assign top = mem_q[sp_m1[IW-1:0]];
  assign sp = sp_q;
  always_comb sp_d = do_push ? sp_q + 1'b1 : do_pop ? sp_m1 : sp_q;
  always_ff @(negedge CLK or negedge RST_N)
    if (!RST_N) sp_q <= '0;
    else sp_q <= sp_d;
  always_ff @(negedge CLK)
    if (do_push) mem_q[sp_q[IW-1:0]] <= din;
endmodule

// File: rtl/pc_stack.sv
// pc_stack: program counter with return-address stack, relative jumps, stall and
// sticky stack error flags; all state changes on the falling clock edge.
module pc_stack
  import pc_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [AW-1:0] RESET_VEC = DEF_RESET_VEC[AW-1:0]
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          stall,
  input  logic          pc_inc,
  input  logic          jmp,
  input  logic          jmp_rel,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] target,
  input  logic          clr_err,
  output logic [AW-1:0] pc,
  output logic          ras_empty,
  output logic          ras_full,
  output logic          ras_ovf,
  output logic          ras_unf
);
  localparam int SW = $clog2(DEPTH + 1);
  op_e op;
  logic [AW-1:0] pc_q, pc_d, pc_p1, top;
  logic [SW-1:0] sp;
  logic ovf_q, ovf_d, unf_q, unf_d, clr;
  assign op = sel_op(stall, ret, call, jmp, jmp_rel, pc_inc);
  assign pc_p1 = pc_q + 1'b1;
  assign clr = clr_err & ~stall;
  ret_stack #(.AW(AW), .DEPTH(DEPTH)) u_ras (
    .CLK(CLK),
    .RST_N(RST_N),
    .push(op == CALL),
    .pop(op == RET),
    .din(pc_p1),
    .top(top),
    .sp(sp),
    .full(ras_full),
    .empty(ras_empty)
  );
  // an AW-bit add is already the sign-extended offset modulo 2^AW
  always_comb begin
    pc_d = op == INC ? pc_p1 :
           (op == JMP || op == CALL) ? target :
           op == JREL ? pc_q + target :
           (op == RET && !ras_empty) ? top : pc_q;
    ovf_d = (op == CALL && ras_full) | (ovf_q & ~clr);
    unf_d = (op == RET && ras_empty) | (unf_q & ~clr);
  end
  always_ff @(negedge CLK or negedge RST_N)
    if (!RST_N) begin
      pc_q <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  assign pc = pc_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;
endmodule
